// File: rtl/riscv_aes_wb_unit.sv
// rtl/riscv_aes_wb_unit.sv - AES result write-back: stores a 128-bit result as four word writes
module riscv_aes_wb_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    res_valid_i,
    input  logic [4*DATA_WIDTH-1:0] res_data_i,
    input  logic [ADDR_WIDTH-1:0]   wb_addr_i,
    output logic                    res_ready_o,
    output logic                    data_req_o,
    input  logic                    data_gnt_i,
    input  logic                    data_rvalid_i,
    input  logic                    data_err_i,
    output logic [ADDR_WIDTH-1:0]   data_addr_o,
    output logic                    data_we_o,
    output logic [3:0]              data_be_o,
    output logic [DATA_WIDTH-1:0]   data_wdata_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              idx_q, idx_d;
    logic [4*DATA_WIDTH-1:0] res_q, res_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic                    err_q, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            res_q   <= '0;
            base_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
            base_q  <= base_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        res_d   = res_q;
        base_d  = base_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (res_valid_i) begin
                    res_d  = res_data_i;
                    base_d = wb_addr_i;
                    idx_d  = 2'd0;
                    // A misaligned base is reported without touching the bus
                    if (wb_addr_i[1:0] != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (data_gnt_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (data_rvalid_i) begin
                    if (data_err_i) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (idx_q == 2'd3) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = S_REQ;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus outputs are zero outside REQ so they match their reset values
    always_comb begin
        data_req_o   = (state_q == S_REQ);
        data_we_o    = data_req_o;
        data_be_o    = {4{data_req_o}};
        data_addr_o  = '0;
        data_wdata_o = '0;
        if (data_req_o) begin
            data_addr_o  = base_q + {{(ADDR_WIDTH-4){1'b0}}, idx_q, 2'b00};
            data_wdata_o = res_q[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign res_ready_o = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);
    assign err_o       = err_q;

endmodule

// File: tb/tb_riscv_aes_wb_unit.sv
// tb/tb_riscv_aes_wb_unit.sv - directed bench for riscv_aes_wb_unit with a logging memory responder
module tb_riscv_aes_wb_unit;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         res_valid_i = 1'b0;
    logic [127:0] res_data_i = '0;
    logic [31:0]  wb_addr_i = '0;
    logic         res_ready_o;
    logic         data_req_o;
    logic         data_gnt_i = 1'b0;
    logic         data_rvalid_i = 1'b0;
    logic         data_err_i = 1'b0;
    logic [31:0]  data_addr_o;
    logic         data_we_o;
    logic [3:0]   data_be_o;
    logic [31:0]  data_wdata_o;
    logic         busy_o;
    logic         done_o;
    logic         err_o;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    riscv_aes_wb_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .res_valid_i(res_valid_i), .res_data_i(res_data_i), .wb_addr_i(wb_addr_i),
        .res_ready_o(res_ready_o),
        .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
        .data_err_i(data_err_i), .data_addr_o(data_addr_o), .data_we_o(data_we_o),
        .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Responder configuration (written by tests) and logs (written only by the responder)
    int gnt_delay [4] = '{0, 0, 0, 0};
    int rv_delay  [4] = '{0, 0, 0, 0};
    int err_word = -1;
    logic [31:0] log_addr [64];
    logic [31:0] log_data [64];
    int          log_cyc  [64];
    int nlog = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    logic done_err = 1'b0;
    int stab_bad = 0;
    int be_bad = 0;
    int word = 0;
    int gnt_cnt = 0;
    int rv_cnt = 0;
    bit pending = 0;
    bit pend_err = 0;
    bit req_active = 0;

    always @(posedge clk) begin
        #1;
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
        data_err_i    = 1'b0;
        if (!rst_n) begin
            pending = 0;
            req_active = 0;
            word = 0;
        end else begin
            if (done_o) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
                done_err = err_o;
                word = 0;
            end
            if (pending) begin
                if (rv_cnt == 0) begin
                    data_rvalid_i = 1'b1;
                    data_err_i    = pend_err;
                    pending = 0;
                end else begin
                    rv_cnt = rv_cnt - 1;
                end
            end else if (data_req_o) begin
                if (!req_active) begin
                    req_active = 1;
                    if (nlog < 64) begin
                        log_addr[nlog] = data_addr_o;
                        log_data[nlog] = data_wdata_o;
                        log_cyc[nlog]  = cyc;
                    end
                    nlog = nlog + 1;
                    gnt_cnt = gnt_delay[word & 3];
                end else if (nlog <= 64 && (data_addr_o !== log_addr[nlog-1] || data_wdata_o !== log_data[nlog-1])) begin
                    stab_bad = stab_bad + 1;
                end
                if (data_be_o !== 4'hF || data_we_o !== 1'b1) be_bad = be_bad + 1;
                if (gnt_cnt == 0) begin
                    data_gnt_i = 1'b1;
                    pending = 1;
                    pend_err = (word == err_word);
                    req_active = 0;
                    rv_cnt = rv_delay[word & 3];
                    word = word + 1;
                end else begin
                    gnt_cnt = gnt_cnt - 1;
                end
            end
        end
    end

    task automatic send(input logic [127:0] d, input logic [31:0] a, output int n);
        for (int i = 0; i < 100 && !res_ready_o; i++) @(negedge clk);
        res_data_i  = d;
        wb_addr_i   = a;
        res_valid_i = 1'b1;
        n = cyc;
        @(posedge clk);
        #2 res_valid_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_done(input int d0, output bit ok);
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (done_cnt > d0) ok = 1;
            else @(negedge clk);
        end
    endtask

    task automatic test_reset;
        tests++; if (data_req_o !== 1'b0) begin fails++; $display("FAIL reset_req got %0b exp 0", data_req_o); end
        tests++; if (data_we_o !== 1'b0 || data_be_o !== 4'h0) begin fails++; $display("FAIL reset_we_be got %0b/%h exp 0/0", data_we_o, data_be_o); end
        tests++; if (data_addr_o !== 32'h0 || data_wdata_o !== 32'h0) begin fails++; $display("FAIL reset_addr_data got %h/%h exp 0/0", data_addr_o, data_wdata_o); end
        tests++; if (done_o !== 1'b0 || err_o !== 1'b0) begin fails++; $display("FAIL reset_done_err got %0b/%0b exp 0/0", done_o, err_o); end
        tests++; if (busy_o !== 1'b0 || res_ready_o !== 1'b1) begin fails++; $display("FAIL reset_busy_ready got %0b/%0b exp 0/1", busy_o, res_ready_o); end
    endtask

    task automatic test_aligned;
        logic [31:0] ea [4] = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
        logic [31:0] ed [4] = '{32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'h00112233};
        int s = nlog, d0 = done_cnt, b0 = be_bad, n;
        bit ok;
        send(128'h00112233_44556677_8899AABB_CCDDEEFF, 32'h0000_1000, n);
        wait_done(d0, ok);
        tests++; if (!ok) begin fails++; $display("FAIL aligned_done_timeout got no done exp done"); end
        tests++; if (nlog - s !== 4) begin fails++; $display("FAIL aligned_count got %0d exp 4", nlog - s); end
        for (int k = 0; k < 4; k++) begin
            tests++; if (log_addr[s+k] !== ea[k] || log_data[s+k] !== ed[k]) begin fails++;
                $display("FAIL aligned_word%0d got %h<-%h exp %h<-%h", k, log_addr[s+k], log_data[s+k], ea[k], ed[k]); end
            tests++; if (log_cyc[s+k] !== n + 1 + 2*k) begin fails++; $display("FAIL aligned_req_cyc%0d got %0d exp %0d", k, log_cyc[s+k] - n, 1 + 2*k); end
        end
        tests++; if (done_cyc !== n + 9 || done_err !== 1'b0) begin fails++; $display("FAIL aligned_done got N+%0d err %0b exp N+9 err 0", done_cyc - n, done_err); end
        tests++; if (res_ready_o !== 1'b0 || busy_o !== 1'b1) begin fails++; $display("FAIL aligned_in_done got ready %0b busy %0b exp 0/1", res_ready_o, busy_o); end
        @(negedge clk);
        tests++; if (res_ready_o !== 1'b1 || done_o !== 1'b0 || err_o !== 1'b0) begin fails++;
            $display("FAIL aligned_after got ready %0b done %0b err %0b exp 1/0/0", res_ready_o, done_o, err_o); end
        tests++; if (be_bad !== b0 || done_cnt - d0 !== 1) begin fails++; $display("FAIL aligned_be_pulse got be_bad %0d pulses %0d exp 0/1", be_bad - b0, done_cnt - d0); end
    endtask

    task automatic test_back_pressure;
        int s = nlog, d0 = done_cnt, st0 = stab_bad, n;
        bit ok;
        gnt_delay = '{0, 3, 0, 0};
        rv_delay  = '{0, 0, 2, 0};
        send(128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0, 32'h0000_4000, n);
        wait_done(d0, ok);
        tests++; if (!ok) begin fails++; $display("FAIL bp_done_timeout got no done exp done"); end
        tests++; if (nlog - s !== 4) begin fails++; $display("FAIL bp_count got %0d exp 4", nlog - s); end
        tests++; if (stab_bad !== st0) begin fails++; $display("FAIL bp_stable got %0d unstable cycles exp 0", stab_bad - st0); end
        tests++; if (log_addr[s+2] !== 32'h4008 || log_data[s+2] !== 32'hA2A2A2A2) begin fails++;
            $display("FAIL bp_word2 got %h<-%h exp 00004008<-a2a2a2a2", log_addr[s+2], log_data[s+2]); end
        tests++; if (done_cyc !== n + 14) begin fails++; $display("FAIL bp_done_cyc got N+%0d exp N+14", done_cyc - n); end
        gnt_delay = '{0, 0, 0, 0};
        rv_delay  = '{0, 0, 0, 0};
        @(negedge clk);
    endtask

    task automatic test_bus_error;
        int s = nlog, d0 = done_cnt, n;
        bit ok;
        err_word = 1;
        send(128'h44444444_33333333_22222222_11111111, 32'h0000_5000, n);
        wait_done(d0, ok);
        err_word = -1;
        tests++; if (!ok) begin fails++; $display("FAIL err_done_timeout got no done exp done"); end
        tests++; if (nlog - s !== 2) begin fails++; $display("FAIL err_count got %0d exp 2", nlog - s); end
        tests++; if (done_cyc !== n + 5 || done_err !== 1'b1) begin fails++; $display("FAIL err_done got N+%0d err %0b exp N+5 err 1", done_cyc - n, done_err); end
        repeat (3) @(negedge clk);
        tests++; if (err_o !== 1'b1) begin fails++; $display("FAIL err_sticky got %0b exp 1", err_o); end
        d0 = done_cnt;
        send(128'h0, 32'h0000_6000, n);
        tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL err_clear got %0b exp 0", err_o); end
        wait_done(d0, ok);
        tests++; if (!ok || done_err !== 1'b0) begin fails++; $display("FAIL err_next_ok got done %0b err %0b exp 1/0", ok, done_err); end
        @(negedge clk);
    endtask

    task automatic test_misaligned;
        int s = nlog, n;
        send(128'h1, 32'h0000_1002, n);
        tests++; if (done_o !== 1'b1 || err_o !== 1'b1) begin fails++; $display("FAIL mis_n1 got done %0b err %0b exp 1/1", done_o, err_o); end
        tests++; if (data_req_o !== 1'b0) begin fails++; $display("FAIL mis_req got %0b exp 0", data_req_o); end
        @(negedge clk);
        tests++; if (res_ready_o !== 1'b1 || done_o !== 1'b0 || err_o !== 1'b1) begin fails++;
            $display("FAIL mis_n2 got ready %0b done %0b err %0b exp 1/0/1", res_ready_o, done_o, err_o); end
        tests++; if (nlog !== s) begin fails++; $display("FAIL mis_no_bus got %0d writes exp 0", nlog - s); end
    endtask

    task automatic test_wrap_ignore;
        logic [31:0] ea [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        logic [31:0] ed [4] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
        int s = nlog, d0 = done_cnt, n;
        bit ok;
        send(128'h0F0E0D0C_0B0A0908_07060504_03020100, 32'hFFFF_FFF8, n);
        @(negedge clk);
        res_data_i = 128'hDEAD; wb_addr_i = 32'h0000_7000; res_valid_i = 1'b1;
        @(negedge clk);
        res_valid_i = 1'b0;
        wait_done(d0, ok);
        repeat (6) @(negedge clk);
        tests++; if (!ok || done_cnt - d0 !== 1) begin fails++; $display("FAIL wrap_pulses got %0d exp 1", done_cnt - d0); end
        tests++; if (nlog - s !== 4) begin fails++; $display("FAIL wrap_count got %0d exp 4", nlog - s); end
        for (int k = 0; k < 4; k++) begin
            tests++; if (log_addr[s+k] !== ea[k] || log_data[s+k] !== ed[k]) begin fails++;
                $display("FAIL wrap_word%0d got %h<-%h exp %h<-%h", k, log_addr[s+k], log_data[s+k], ea[k], ed[k]); end
        end
    endtask

    task automatic test_reset_mid;
        int s = nlog, d0 = done_cnt, n;
        bit ok;
        send(128'h1, 32'h0000_2000, n);
        for (int i = 0; i < 50 && !(nlog - s == 3 && data_req_o); i++) @(negedge clk);
        tests++; if (nlog - s !== 3 || data_req_o !== 1'b1 || data_addr_o !== 32'h2008) begin fails++;
            $display("FAIL rst_reach_word2 got writes %0d req %0b addr %h exp 3/1/00002008", nlog - s, data_req_o, data_addr_o); end
        #1 rst_n = 1'b0;
        #1;
        tests++; if (data_req_o !== 1'b0 || data_addr_o !== 32'h0 || data_wdata_o !== 32'h0 || data_be_o !== 4'h0) begin fails++;
            $display("FAIL rst_async_bus got req %0b addr %h data %h be %h exp 0", data_req_o, data_addr_o, data_wdata_o, data_be_o); end
        tests++; if (busy_o !== 1'b0 || res_ready_o !== 1'b1 || done_o !== 1'b0 || err_o !== 1'b0) begin fails++;
            $display("FAIL rst_async_ctl got busy %0b ready %0b done %0b err %0b exp 0/1/0/0", busy_o, res_ready_o, done_o, err_o); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (done_cnt !== d0) begin fails++; $display("FAIL rst_no_done got %0d pulses exp 0", done_cnt - d0); end
        s = nlog;
        send(128'hBBBB0003_BBBB0002_BBBB0001_BBBB0000, 32'h0000_3000, n);
        wait_done(d0, ok);
        tests++; if (!ok || done_cyc !== n + 9 || nlog - s !== 4) begin fails++;
            $display("FAIL rst_recover got done %0b N+%0d writes %0d exp 1 N+9 4", ok, done_cyc - n, nlog - s); end
        tests++; if (log_addr[s+3] !== 32'h300C || log_data[s+3] !== 32'hBBBB0003) begin fails++;
            $display("FAIL rst_recover_last got %h<-%h exp 0000300c<-bbbb0003", log_addr[s+3], log_data[s+3]); end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        @(negedge clk);
        test_aligned;
        test_back_pressure;
        test_bus_error;
        test_misaligned;
        test_wrap_ignore;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/riscv_aes_wb_unit.md
# riscv_aes_wb_unit

Write-back stage of the RISC-V AES accelerator. It sits downstream of the AES register file and AES datapath. It captures a 128-bit AES result together with the 32-bit write-back base address held in the AES register file. It then stores the result to data memory as four word writes over an OBI-style request/grant/rvalid port, and reports completion or bus error to the core.

## Interface
- DATA_WIDTH, 32, width of one memory word and data bus
- ADDR_WIDTH, 32, width of the memory address and of the write-back base address
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- res_valid_i  input  1  AES result valid; accepted only when res_ready_o=1
- res_data_i  input  4*DATA_WIDTH  AES result; word k = bits [32k+31:32k]
- wb_addr_i  input  ADDR_WIDTH  write-back base address, sampled with the result
- res_ready_o  input-side handshake  output  1  unit idle and able to accept a result
- data_req_o  output  1  memory request
- data_gnt_i  input  1  memory grant
- data_rvalid_i  input  1  write response valid, at least 1 cycle after grant
- data_err_i  input  1  bus error, meaningful only with data_rvalid_i
- data_addr_o  output  ADDR_WIDTH  word address of current write
- data_we_o  output  1  write enable; equals data_req_o
- data_be_o  output  4  byte enables; 4'hF while data_req_o=1, else 4'h0
- data_wdata_o  output  DATA_WIDTH  current word
- busy_o  output  1  state is not IDLE
- done_o  output  1  one-cycle completion pulse
- err_o  output  1  sticky error flag, cleared on next accepted result

## Operation
- States: IDLE, REQ, WAIT, DONE. Word counter idx, 2 bits. Registers: result, base address, error flag.
- IDLE: res_ready_o=1. On res_valid_i=1:
  - capture res_data_i and wb_addr_i, set idx=0, clear err_o.
  - If wb_addr_i[1:0]≠0, set err_o=1 and go to DONE; no bus traffic.
  - Otherwise go to REQ.
- res_valid_i in any state other than IDLE is ignored; no queueing.
- REQ:
  - data_req_o=1, data_addr_o = base + 4*idx (modulo 2^ADDR_WIDTH, wrap permitted), data_wdata_o = word idx.
  - Address and data stay stable until grant.
  - On data_gnt_i=1, go to WAIT.
- WAIT: data_req_o=0. On data_rvalid_i=1:
  - if data_err_i=1, set err_o=1 and go to DONE; remaining words are aborted.
  - else if idx=3, go to DONE.
  - else idx+1 and go to REQ.
- One outstanding transaction maximum. data_rvalid_i outside WAIT is ignored.
- DONE: done_o=1 for exactly one cycle, res_ready_o=0, then go to IDLE.
- err_o holds its value from DONE until the next accepted result.

## Timing
- Reset values:
  - data_req_o=0, data_we_o=0, data_be_o=0, data_addr_o=0, data_wdata_o=0
  - done_o=0, err_o=0, busy_o=0, res_ready_o=1, state IDLE, idx=0.
- Reset mid-operation: async return to IDLE; data_req_o drops immediately. Pending words are lost and no done_o is issued.
- Acceptance at cycle N puts data_req_o=1 at N+1.
- Zero-wait bus (gnt same cycle, rvalid next cycle):
  - requests at N+1, N+3, N+5, N+7
  - last rvalid at N+8
  - done_o at N+9
  - res_ready_o=1 at N+10
- Minimum 2 cycles per word. Each extra grant or rvalid wait cycle adds one cycle.
- Misaligned address: done_o and err_o=1 at N+1; res_ready_o=1 at N+2.
- Grant delay: request held with identical addr/data through any number of no-grant cycles.

## Test plan
- Aligned store: base 0x0000_1000, result 0x00112233_44556677_8899AABB_CCDDEEFF, zero-wait bus.
  - Writes: 0x1000←0xCCDDEEFF, 0x1004←0x8899AABB, 0x1008←0x44556677, 0x100C←0x00112233.
  - done_o at N+9; err_o=0.
- Backpressure: grant withheld 3 cycles on word 1, rvalid delayed 2 cycles on word 2.
  - addr/wdata stable while waiting; exactly 4 writes; done_o 5 cycles later than the zero-wait case.
- Bus error: data_err_i=1 with rvalid of word 1.
  - Only words 0-1 issued; done_o next cycle; err_o=1 until the next accepted result, which clears it.
- Misaligned base 0x0000_1002: no data_req_o; done_o and err_o=1 at N+1.
- Wrap and ignored input: base 0xFFFF_FFF8.
  - Addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004.
  - A second res_valid_i pulse while busy produces no extra writes.
- Reset mid-operation: assert rst_n=0 during word 2 REQ.
  - data_req_o=0 immediately; all outputs at reset values; a new result afterwards completes normally.
